// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - write-posting store FIFO with load forwarding and DataB bus arbitration
// Optional in-place store merging is enabled by defining STORE_COALESCE_EN.
module store_buffer #(
  parameter int W     = 8,
  parameter int A     = 8,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         StoreValid,
  input  logic [A-1:0] StoreAddr,
  input  logic [W-1:0] StoreData,
  output logic         StoreReady,
  input  logic         LoadValid,
  input  logic [A-1:0] LoadAddr,
  output logic [W-1:0] LoadData,
  output logic         LoadHit,
  output logic         MemWriteEn,
  output logic [A-1:0] MemWrAddr,
  output logic [W-1:0] MemBus,
  input  logic [W-1:0] MemReadData,
  output logic         Empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [A-1:0]     addr_q [DEPTH];
  logic [W-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;

  logic          fwd_hit;
  logic [W-1:0]  fwd_data;
  logic [PW-1:0] lk_idx;
  logic          load_miss, drain, accept, alloc, not_full;
  logic          co_hit;
  logic [PW-1:0] co_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    lk_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PW'(i);
      if (valid_q[lk_idx] && addr_q[lk_idx] == LoadAddr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[lk_idx];
      end
    end
  end

  assign LoadHit   = LoadValid && fwd_hit;
  assign load_miss = LoadValid && !fwd_hit;
  assign LoadData  = LoadHit ? fwd_data : MemReadData;
  // Gating with Reset keeps memory from writing on the reset edge itself.
  assign drain     = (count_q != '0) && !load_miss && !Reset;
  assign not_full  = (count_q != CW'(DEPTH));

`ifdef STORE_COALESCE_EN
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == StoreAddr && !(drain && PW'(i) == head_q)) begin
        co_hit = 1'b1;
        co_idx = PW'(i);
      end
    end
  end
  assign StoreReady = not_full || co_hit;
`else
  assign co_hit     = 1'b0;
  assign co_idx     = '0;
  assign StoreReady = not_full;
`endif

  assign accept     = StoreValid && StoreReady;
  assign alloc      = accept && !co_hit;
  assign MemWriteEn = drain;
  assign MemWrAddr  = addr_q[head_q];
  assign MemBus     = load_miss ? W'(LoadAddr) : data_q[head_q];
  assign Empty      = (count_q == '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (accept && co_hit) begin
        data_q[co_idx] <= StoreData;
      end
      if (alloc) begin
        addr_q[tail_q]  <= StoreAddr;
        data_q[tail_q]  <= StoreData;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(alloc) - CW'(drain);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
// Test 6 runs only when STORE_COALESCE_EN is defined.
module tb_store_buffer;
  logic       Clk = 1'b0;
  logic       Reset;
  logic       StoreValid;
  logic [7:0] StoreAddr;
  logic [7:0] StoreData;
  logic       StoreReady;
  logic       LoadValid;
  logic [7:0] LoadAddr;
  logic [7:0] LoadData;
  logic       LoadHit;
  logic       MemWriteEn;
  logic [7:0] MemWrAddr;
  logic [7:0] MemBus;
  logic [7:0] MemReadData;
  logic       Empty;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int base;
  logic [7:0] mem [256];

  store_buffer #(.W(8), .A(8), .DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .StoreValid(StoreValid), .StoreAddr(StoreAddr), .StoreData(StoreData), .StoreReady(StoreReady),
    .LoadValid(LoadValid), .LoadAddr(LoadAddr), .LoadData(LoadData), .LoadHit(LoadHit),
    .MemWriteEn(MemWriteEn), .MemWrAddr(MemWrAddr), .MemBus(MemBus),
    .MemReadData(MemReadData), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  // Simple data memory: DataB is the read address on loads, write data on writes.
  assign MemReadData = mem[MemBus];
  always @(posedge Clk) begin
    if (MemWriteEn) begin
      mem[MemWrAddr] <= MemBus;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    StoreValid = 1'b1;
    StoreAddr  = a;
    StoreData  = d;
    #1;
    check("store_ready", StoreReady, 1);
    step();
    StoreValid = 1'b0;
  endtask

`ifdef STORE_COALESCE_EN
  localparam logic [7:0] T3_HEAD = 8'h22;
`else
  localparam logic [7:0] T3_HEAD = 8'h11;
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h40] = 8'h33;
    Reset = 1'b1; StoreValid = 1'b0; StoreAddr = '0; StoreData = '0;
    LoadValid = 1'b0; LoadAddr = '0;
    step(); step();

    // 1: reset state and a single store drained the next cycle
    Reset = 1'b0;
    #1;
    check("rst_ready", StoreReady, 1);
    check("rst_empty", Empty, 1);
    check("rst_wen", MemWriteEn, 0);
    check("rst_hit", LoadHit, 0);
    store(8'h10, 8'h5A);
    #1;
    check("t1_wen", MemWriteEn, 1);
    check("t1_addr", MemWrAddr, 8'h10);
    check("t1_bus", MemBus, 8'h5A);
    step();
    #1;
    check("t1_empty", Empty, 1);
    check("t1_wen_off", MemWriteEn, 0);
    check("t1_mem", mem[8'h10], 8'h5A);

    // 2: missing load blocks drain until full; fifth store is held
    base = wr_cnt;
    LoadValid = 1'b1; LoadAddr = 8'h80;
    for (int i = 1; i <= 4; i++) begin
      StoreValid = 1'b1; StoreAddr = 8'(i); StoreData = 8'hA0 + 8'(i);
      #1;
      check("t2_ready", StoreReady, 1);
      check("t2_blocked", MemWriteEn, 0);
      check("t2_bus", MemBus, 8'h80);
      step();
    end
    StoreAddr = 8'h05; StoreData = 8'hA5;
    #1;
    check("t2_full", StoreReady, 0);
    step();
    LoadValid = 1'b0;
    #1;
    check("t2_full_drain", StoreReady, 0);
    check("t2_wen1", MemWriteEn, 1);
    check("t2_addr1", MemWrAddr, 8'h01);
    check("t2_bus1", MemBus, 8'hA1);
    step();
    #1;
    check("t2_ready2", StoreReady, 1);
    check("t2_addr2", MemWrAddr, 8'h02);
    check("t2_bus2", MemBus, 8'hA2);
    step();
    StoreValid = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      #1;
      check("t2_wen", MemWriteEn, 1);
      check("t2_addr", MemWrAddr, 8'(k));
      check("t2_data", MemBus, 8'hA0 + 8'(k));
      step();
    end
    #1;
    check("t2_empty", Empty, 1);
    check("t2_writes", wr_cnt - base, 5);

    // 3: youngest-match forwarding while the older entry drains
    LoadValid = 1'b1; LoadAddr = 8'h80;
    store(8'h20, 8'h11);
    store(8'h20, 8'h22);
    LoadAddr = 8'h20;
    #1;
    check("t3_hit", LoadHit, 1);
    check("t3_data", LoadData, 8'h22);
    check("t3_wen", MemWriteEn, 1);
    check("t3_addr", MemWrAddr, 8'h20);
    check("t3_bus", MemBus, T3_HEAD);
    step();
    LoadValid = 1'b0;
    step(); step();
    #1;
    check("t3_empty", Empty, 1);
    check("t3_mem", mem[8'h20], 8'h22);

    // 4: load miss passes address through and returns memory data
    LoadValid = 1'b1; LoadAddr = 8'h40;
    #1;
    check("t4_hit", LoadHit, 0);
    check("t4_bus", MemBus, 8'h40);
    check("t4_wen", MemWriteEn, 0);
    check("t4_data", LoadData, 8'h33);

    // 5: reset with pending entries discards them without a write
    LoadAddr = 8'h80;
    store(8'h61, 8'h01);
    store(8'h62, 8'h02);
    store(8'h63, 8'h03);
    LoadValid = 1'b0; Reset = 1'b1;
    #1;
    check("t5_wen_rst", MemWriteEn, 0);
    base = wr_cnt;
    step();
    Reset = 1'b0;
    #1;
    check("t5_empty", Empty, 1);
    check("t5_ready", StoreReady, 1);
    for (int k = 0; k < 3; k++) begin
      check("t5_wen", MemWriteEn, 0);
      step();
    end
    check("t5_writes", wr_cnt - base, 0);
    check("t5_mem", mem[8'h61], 8'h00);

`ifdef STORE_COALESCE_EN
    // 6: same-address stores merge into one entry
    LoadValid = 1'b1; LoadAddr = 8'h80;
    store(8'h30, 8'hAA);
    store(8'h30, 8'hBB);
    base = wr_cnt;
    LoadValid = 1'b0;
    #1;
    check("t6_wen", MemWriteEn, 1);
    check("t6_addr", MemWrAddr, 8'h30);
    check("t6_bus", MemBus, 8'hBB);
    step();
    #1;
    check("t6_empty", Empty, 1);
    step();
    check("t6_writes", wr_cnt - base, 1);
    check("t6_mem", mem[8'h30], 8'hBB);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-posting FIFO between the core's load/store stage and the 8-bit data memory.
- Accepts stores and retires them to memory one per cycle, only on cycles when the shared memory bus is free.
- Serves loads by forwarding the youngest matching buffered store, or by passing the load address through to memory.
- The memory's single DataB bus carries either the load read address or the store write data. This block owns the arbitration of that bus.

Parameters:
- W, 8, data width.
- A, 8, address width.
- DEPTH, 4, buffer entries; power of 2, ≥2.

Ports:
- Clk  in  1  clock, all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- StoreValid  in  1  store request this cycle.
- StoreAddr  in  A  store address.
- StoreData  in  W  store data.
- StoreReady  out  1  buffer can accept a store this cycle.
- LoadValid  in  1  load request this cycle.
- LoadAddr  in  A  load address.
- LoadData  out  W  load result, combinational.
- LoadHit  out  1  load was served from the buffer.
- MemWriteEn  out  1  to memory WriteEn.
- MemWrAddr  out  A  to memory DataA.
- MemBus  out  W  to memory DataB: read address on a load miss, write data on a drain.
- MemReadData  in  W  from memory DataOut.
- Empty  out  1  no entries pending; program done-logic waits on this.

Behaviour:
- Reset (synchronous, active-high, one Clk edge):
  - Head, tail and count are cleared; all entries are invalidated.
  - StoreReady=1, Empty=1, MemWriteEn=0, LoadHit=0.
  - Reset mid-operation discards pending stores; no memory write occurs on or after the reset edge.
- Storage:
  - Circular FIFO of {addr, data}.
  - Count width is $clog2(DEPTH+1).
  - Pointers wrap modulo DEPTH.
- Enqueue:
  - StoreReady = (count != DEPTH). It is not raised by a same-cycle drain, so there is no pass-through when full.
  - A store is accepted at the posedge when StoreValid && StoreReady.
  - The earliest drain of that entry is the following cycle.
- Load lookup:
  - Compares LoadAddr against valid entries present at the start of the cycle.
  - A store being enqueued in the same cycle is not visible to that load.
  - On a match: LoadHit=1 and LoadData = data of the youngest matching entry.
  - On no match: LoadHit=0, LoadData = MemReadData, MemBus = LoadAddr.
  - When LoadValid=0: LoadHit=0.
- Drain:
  - Condition: count != 0 && (!LoadValid || LoadHit).
  - Drain outputs: MemWriteEn=1, MemWrAddr = head addr, MemBus = head data.
  - The head advances at the posedge.
  - Loads that miss always win the bus. A continuous stream of missing loads stalls draining, which stalls stores via StoreReady.
- Simultaneous events:
  - Enqueue and drain in the same cycle leave count unchanged.
  - A hitting load and a drain in the same cycle are both allowed; forwarding still sees the draining entry that cycle.
- Default bus value: when neither a load miss nor a drain is active, MemBus = head data and MemWriteEn=0.
- Empty = (count == 0), registered state only.
- Ordering: memory sees stores in program order; no coalescing unless the optional feature is enabled.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- With the macro defined:
  - An accepted store whose address matches a valid entry overwrites that entry's data in place; count is unchanged.
  - Exception: an entry being drained in the same cycle is never coalesced into; the store enqueues normally instead.
  - Because entries never duplicate addresses, StoreReady is also 1 when the buffer is full and the incoming address matches a non-draining entry.
- Without the macro: every accepted store allocates a new entry; duplicate addresses are allowed; forwarding picks the youngest.

Test Plan:
1. Reset, then a single store 0x10<=0x5A with LoadValid=0 -> next cycle MemWriteEn=1, MemWrAddr=0x10, MemBus=0x5A; cycle after, Empty=1 and MemWriteEn=0.
2. Hold a missing load to 0x80 while issuing stores to 0x01..0x05 -> StoreReady=0 after the 4th store, 5th store held; release the load -> writes 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles.
3. Under a blocking load, store 0x20<=0x11 then 0x20<=0x22; load 0x20 -> LoadHit=1, LoadData=0x22, and a drain of head 0x20/0x11 occurs the same cycle.
4. Load to 0x40 (no match, memory holds 0x33 at 0x40) -> LoadHit=0, MemBus=0x40, MemWriteEn=0, LoadData=0x33.
5. Three entries pending, assert Reset for 1 cycle with LoadValid=0 -> Empty=1, StoreReady=1, no MemWriteEn pulse on or after the reset edge.
6. With STORE_COALESCE_EN, under a blocking load store 0x30<=0xAA then 0x30<=0xBB -> count=1; after release, exactly one write of 0x30<=0xBB.
